// File: rtl/vga_pkg.sv
// VGA timing defaults, grid geometry and shared colour codes for the snake game.
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned TICK_FRAMES_DEF = 6;
  localparam int unsigned TICK_CNT_W      = 8;

  localparam int unsigned GRID_W = 32;
  localparam int unsigned GRID_H = 24;
  localparam int unsigned CELL_W = 20;
  localparam int unsigned CELL_H = 20;

  localparam int unsigned COLOR_W = 3;
  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t COL_BLACK  = 3'b000;
  localparam color_t COL_BLUE   = 3'b001;
  localparam color_t COL_GREEN  = 3'b010;
  localparam color_t COL_CYAN   = 3'b011;
  localparam color_t COL_RED    = 3'b100;
  localparam color_t COL_YELLOW = 3'b110;
  localparam color_t COL_WHITE  = 3'b111;

  // True when lo <= v < hi.
  function automatic logic in_range(input logic [COORD_W-1:0] v,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Video timing bus from the timing generator to the pixel/snake logic.
interface vga_timing_if;
  import vga_pkg::*;

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               active;
  logic               hsync;
  logic               vsync;
  logic               vblank_start;
  logic               tick;

  modport master (output x, y, active, hsync, vsync, vblank_start, tick);
  modport slave  (input  x, y, active, hsync, vsync, vblank_start, tick);
endinterface

// File: rtl/snake_tick_div.sv
// Divides vblank pulses down to a game tick; tick is registered alongside
// the vblank_start pulse that wraps the frame counter.
module snake_tick_div
  import vga_pkg::*;
#(
  parameter int unsigned TICK_FRAMES = TICK_FRAMES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_frame,
  output logic o_tick
);

  logic [TICK_CNT_W-1:0] r_cnt;
  logic                  r_tick;

  // Frame counter 0..TICK_FRAMES-1; tick on the wrapping frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_frame) begin
        if (r_cnt == TICK_CNT_W'(TICK_FRAMES - 1)) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_cnt <= r_cnt + TICK_CNT_W'(1);
        end
      end
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator with optional game-tick divider.
// Define SNAKE_TICK_EN to build the frame-to-tick divider; otherwise tick is 0.
// Every output is registered from the next (h,v), so all of them describe
// the same pixel as x/y in any given cycle.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned H_FP        = H_FP_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned V_FP        = V_FP_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter int unsigned TICK_FRAMES = TICK_FRAMES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  vga_timing_if.master  vga
);

  localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Elaboration guard on the tick divider range.
  if (TICK_FRAMES < 1 || TICK_FRAMES > 255) begin : g_bad_tick_frames
    $error("vga_timing: TICK_FRAMES must be in 1..255");
  end

  logic [COORD_W-1:0] r_h;
  logic [COORD_W-1:0] r_v;
  logic               r_active;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_vbs;

  logic               w_h_wrap;
  logic [COORD_W-1:0] w_h_nxt;
  logic [COORD_W-1:0] w_v_nxt;
  logic               w_vbs_nxt;
  logic               w_tick;

  // Next raster position; v advances only when h wraps.
  always_comb begin
    w_h_wrap  = (r_h == COORD_W'(H_TOT - 1));
    w_h_nxt   = r_h + COORD_W'(1);
    w_v_nxt   = r_v;
    if (w_h_wrap) begin
      w_h_nxt = '0;
      if (r_v == COORD_W'(V_TOT - 1)) begin
        w_v_nxt = '0;
      end else begin
        w_v_nxt = r_v + COORD_W'(1);
      end
    end
    w_vbs_nxt = (w_h_nxt == '0) && (w_v_nxt == COORD_W'(V_ACTIVE));
  end

  // Counters and decoded outputs, all registered from the same next position.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h      <= COORD_W'(H_TOT - 1);
      r_v      <= COORD_W'(V_TOT - 1);
      r_active <= 1'b0;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
      r_vbs    <= 1'b0;
    end else begin
      r_h      <= w_h_nxt;
      r_v      <= w_v_nxt;
      r_active <= in_range(w_h_nxt, 0, H_ACTIVE) && in_range(w_v_nxt, 0, V_ACTIVE);
      r_hsync  <= !in_range(w_h_nxt, HS_START, HS_END);
      r_vsync  <= !in_range(w_v_nxt, VS_START, VS_END);
      r_vbs    <= w_vbs_nxt;
    end
  end

`ifdef SNAKE_TICK_EN
  snake_tick_div #(
    .TICK_FRAMES (TICK_FRAMES)
  ) u_tick_div (
    .clk     (clk),
    .reset   (reset),
    .i_frame (w_vbs_nxt),
    .o_tick  (w_tick)
  );
`else
  assign w_tick = 1'b0;
`endif

  assign vga.x            = r_h;
  assign vga.y            = r_v;
  assign vga.active       = r_active;
  assign vga.hsync        = r_hsync;
  assign vga.vsync        = r_vsync;
  assign vga.vblank_start = r_vbs;
  assign vga.tick         = w_tick;

endmodule
